data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 10, giving the number of address bits used for word indexing (DEPTH = 2^ADDR_W = 1024 words).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all writes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port DMin, input, DATA_W bits: write data.
REQ-006 The block SHALL have port DMaddr, input, 32 bits: word address; only bits [ADDR_W-1:0] are used.
REQ-007 The block SHALL have port DMwr, input, 1 bit: write enable, active-high.
REQ-008 The block SHALL have port DMout, output, DATA_W bits: read data.

Function
REQ-009 The block SHALL store DEPTH words of DATA_W bits each, addressed per word (address 15 selects word 15, not a byte offset).
REQ-010 The block SHALL form the word index as DMaddr[ADDR_W-1:0] and ignore bits [31:ADDR_W]; addresses ≥ DEPTH therefore alias modulo DEPTH, with no error flag.
REQ-011 Write: on each rising clk edge with rst=1 and DMwr=1, the block SHALL store DMin into word[index]; all other words remain unchanged.
REQ-012 With DMwr=0, a rising clk edge SHALL leave memory contents unchanged.
REQ-013 Read: DMout SHALL be combinational (zero-cycle latency).
   - DMout = word[index] for the current DMaddr.
   - DMout updates whenever DMaddr or the addressed word changes.
REQ-014 Read-during-write to the same address SHALL behave as follows:
   - Before the clock edge, DMout shows the old contents.
   - After the edge, DMout shows the newly written DMin.
   - There is no write-through bypass.
REQ-015 DMin and DMaddr SHALL be sampled at the rising edge for writes; changes between edges SHALL not alter stored data.
REQ-016 The block SHALL have no handshake, no busy signal and no stall; one write per cycle is always accepted.

Reset
REQ-017 While rst=0, the block SHALL asynchronously clear every word to 0, independent of clk.
REQ-018 While rst=0, DMout SHALL read 0 for any address.
REQ-019 Writes SHALL be suppressed while rst=0, even if DMwr=1 at a clock edge.
REQ-020 Reset asserted in the middle of operation SHALL clear all previously written data.
REQ-021 After rst returns to 1, the first rising edge with DMwr=1 SHALL perform a normal write.

Verification
REQ-022 Reset/read: with rst=0, DMaddr=15 and DMwr=0, DMout SHALL be 0x00000000; after rst rises with DMwr still 0, DMout SHALL remain 0.
REQ-023 Single write: with rst=1, DMaddr=15, DMin=0x12345678 and DMwr=1 over one rising edge:
   - DMout SHALL be 0 before the edge.
   - DMout SHALL be 0x12345678 immediately after the edge.
   - DMout SHALL hold that value after DMwr falls.
REQ-024 Write suppression: with rst=0 and DMwr=1, apply a rising edge at address 15 with DMin=0xDEADBEEF; after releasing reset, DMout at address 15 SHALL read 0.
REQ-025 Isolation/aliasing:
   - Write 0xAAAA0001 to address 3 and 0x5555000F to address 1027.
   - Address 3 SHALL then read 0x5555000F (alias of 1027).
   - Address 4 SHALL read 0.
REQ-026 Async clear mid-operation: after writing 0x12345678 to address 15, pulse rst low between clock edges; DMout SHALL drop to 0 without any clock edge and SHALL stay 0 after rst rises.

Source files
------------

// File: rtl/data_memory.sv
// Word-addressed DEPTH x DATA_W data memory with asynchronous clear; combinational read (0 cycles).
// Writes land on the rising clk edge; no backpressure, one write is accepted every cycle.
module data_memory #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] DMin,
  input  logic [31:0]       DMaddr,
  input  logic              DMwr,
  output logic [DATA_W-1:0] DMout
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] idx;
  logic              unused_addr_hi;

  // Upper address bits alias modulo DEPTH by construction.
  assign idx            = DMaddr[ADDR_W-1:0];
  assign unused_addr_hi = ^DMaddr[31:ADDR_W];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (DMwr) begin
      mem_q[idx] <= DMin;
    end
  end

  // Gating on rst keeps the output at zero in the same instant reset asserts.
  assign DMout = rst ? mem_q[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, write/read, suppression, aliasing, async clear.
module tb_data_memory;

  logic        clk;
  logic        rst;
  logic [31:0] DMin;
  logic [31:0] DMaddr;
  logic        DMwr;
  logic [31:0] DMout;

  int pass_cnt;
  int total_cnt;

  data_memory #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk    (clk),
    .rst    (rst),
    .DMin   (DMin),
    .DMaddr (DMaddr),
    .DMwr   (DMwr),
    .DMout  (DMout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    DMaddr = addr;
    DMin   = data;
    DMwr   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    DMwr = 1'b0;
  endtask

  task automatic read_word(input logic [31:0] addr, input string tag, input logic [31:0] exp);
    DMaddr = addr;
    #1;
    check(tag, DMout, exp);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst    = 1'b0;
    DMwr   = 1'b0;
    DMaddr = 32'd15;
    DMin   = 32'h0;
    #1;
    check("reset_read_15", DMout, 32'h0000_0000);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check("after_reset_read_15", DMout, 32'h0000_0000);

    // Single write with read-during-write
    @(negedge clk);
    DMaddr = 32'd15;
    DMin   = 32'h1234_5678;
    DMwr   = 1'b1;
    #1;
    check("rdw_before_edge", DMout, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("rdw_after_edge", DMout, 32'h1234_5678);
    @(negedge clk);
    DMwr = 1'b0;
    #1;
    check("hold_after_wr_low", DMout, 32'h1234_5678);

    // DMin changes with DMwr low leave memory alone
    DMin = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("no_write_when_wr_low", DMout, 32'h1234_5678);

    // Only the value present at the edge is stored
    @(negedge clk);
    DMaddr = 32'd20;
    DMin   = 32'h1111_1111;
    DMwr   = 1'b1;
    #2;
    DMin = 32'h2222_2222;
    @(posedge clk);
    #1;
    check("sampled_at_edge", DMout, 32'h2222_2222);
    @(negedge clk);
    DMwr = 1'b0;
    read_word(32'd15, "neighbour_untouched", 32'h1234_5678);

    // Async clear between edges, then suppressed write during reset
    @(negedge clk);
    DMaddr = 32'd15;
    #2;
    rst = 1'b0;
    #1;
    check("async_clear_no_edge", DMout, 32'h0000_0000);
    DMin = 32'hDEAD_BEEF;
    DMwr = 1'b1;
    @(posedge clk);
    #1;
    check("out_zero_in_reset", DMout, 32'h0000_0000);
    @(negedge clk);
    DMwr = 1'b0;
    rst  = 1'b1;
    #1;
    check("write_suppressed_15", DMout, 32'h0000_0000);
    read_word(32'd20, "cleared_20", 32'h0000_0000);

    // Aliasing modulo DEPTH
    write_word(32'd3, 32'hAAAA_0001);
    read_word(32'd4, "isolation_4_a", 32'h0000_0000);
    write_word(32'd1027, 32'h5555_000F);
    read_word(32'd3, "alias_3", 32'h5555_000F);
    read_word(32'd1027, "alias_1027", 32'h5555_000F);
    read_word(32'hFFFF_FC03, "alias_high_bits", 32'h5555_000F);
    read_word(32'd4, "isolation_4_b", 32'h0000_0000);

    // Address boundaries
    write_word(32'd1023, 32'hA5A5_5A5A);
    write_word(32'd0, 32'h0F0F_F0F0);
    read_word(32'd1023, "top_word", 32'hA5A5_5A5A);
    read_word(32'd0, "bottom_word", 32'h0F0F_F0F0);
    read_word(32'd1024, "alias_1024", 32'h0F0F_F0F0);

    // First edge after reset release performs a normal write
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    DMaddr = 32'd7;
    DMin   = 32'hCAFE_F00D;
    DMwr   = 1'b1;
    @(posedge clk);
    #1;
    check("first_write_after_reset", DMout, 32'hCAFE_F00D);
    @(negedge clk);
    DMwr = 1'b0;
    read_word(32'd1023, "cleared_top", 32'h0000_0000);
    read_word(32'd3, "cleared_3", 32'h0000_0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
